uart_rx_frontend: RTL
=====================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 104, meaning clk cycles per bit (12 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx  input  1  raw asynchronous serial line (rs232_rx_ttl), idle high.
REQ-005 SHALL have port data_o  output  8  received byte, LSB received first.
REQ-006 SHALL have port valid_o  output  1  data_o holds an unconsumed byte.
REQ-007 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-008 SHALL have port framing_error_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse: completed byte dropped because holding register was full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized signal (rxs); 2-cycle input latency.
REQ-011 SHALL implement states IDLE, START, DATA, STOP with baud counter 0..CLOCKS_PER_BAUD-1 and 3-bit bit index.
REQ-012 SHALL, in IDLE, on rxs high-to-low transition, clear the baud counter and enter START.
REQ-013 SHALL take three samples per bit at counts M-1, M, M+1 (M = CLOCKS_PER_BAUD/2, integer division) and use the 2-of-3 majority as the bit value.
REQ-014 SHALL, in START, return to IDLE at count M+1 if majority is 1 (glitch rejection, no output pulse); otherwise enter DATA at counter wrap with bit index 0.
REQ-015 SHALL, in DATA, shift majority into a shift register LSB first, incrementing bit index at each wrap; enter STOP after the wrap that ends bit 7.
REQ-016 SHALL, in STOP, decide at count M+1 and go to IDLE on the next cycle (half-bit early, permits back-to-back frames).
REQ-017 SHALL, on stop majority 1, load data_o and set valid_o on the following edge if holding register empty or being consumed that cycle.
REQ-018 SHALL, on stop majority 1 with valid_o high and ready_i low, keep old data_o, discard the new byte, pulse overrun_o.
REQ-019 SHALL, on stop majority 0, discard the byte, pulse framing_error_o, leave data_o/valid_o unchanged.
REQ-020 SHALL clear valid_o on the edge after valid_o && ready_i unless a new byte is loaded in that same cycle (new byte wins, valid_o stays high).
REQ-021 SHALL hold data_o stable while valid_o is high and ready_i low.
REQ-022 SHALL ignore ready_i while valid_o is low.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force: state IDLE, counters 0, synchronizer flops 1, data_o 0x00, valid_o 0, framing_error_o 0, overrun_o 0.
REQ-024 SHALL abandon any partial frame on reset mid-frame; after release, the first falling edge seen on rxs starts a new frame.

Structure
REQ-025 SHALL take the state enum and CLOCKS_PER_BAUD default from shared package uart_pkg, also used by the matching transmitter.
REQ-026 SHALL instantiate the 2-flop synchronizer as sub-module rx_synchronizer (reset value 1); all other logic stays in uart_rx_frontend.

Verification
REQ-027 SHALL cover: send 0xA5 at CLOCKS_PER_BAUD=104, ready_i high -> data_o=0xA5, valid_o high exactly 1 cycle, no error pulses.
REQ-028 SHALL cover: rx low pulse of 20 cycles in IDLE -> no valid_o, no framing_error_o, state back to IDLE by count M+1.
REQ-029 SHALL cover: send 0x3C with stop bit forced low -> framing_error_o 1 cycle, valid_o stays 0.
REQ-030 SHALL cover: ready_i held low, send 0x11 then 0x22 back-to-back -> data_o=0x11 held, overrun_o pulses once at the second stop bit.
REQ-031 SHALL cover: valid_o high with 0x11, ready_i asserted in the same cycle 0x22 completes -> data_o=0x22, valid_o stays 1, no overrun_o.
REQ-032 SHALL cover: rst_n pulsed low mid-DATA of 0xFF, then 0x5A sent -> only 0x5A reported; all outputs at reset values during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for receiver and transmitter
package uart_pkg;

  // 12 MHz system clock / 115200 baud
  localparam int unsigned CLOCKS_PER_BAUD_DEFAULT = 104;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 2-of-3 vote used to filter each bit
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// rtl/rx_synchronizer.sv - two-flop synchronizer for an asynchronous input
module rx_synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; reset to the line's idle level so no false edge appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - UART receiver with majority sampling and one-byte holding register
import uart_pkg::*;

module uart_rx_frontend #(
  parameter int unsigned CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       framing_error_o,
  output logic       overrun_o
);

  localparam logic [15:0] LAST = 16'(CLOCKS_PER_BAUD - 1);
  localparam logic [15:0] MID  = 16'(CLOCKS_PER_BAUD / 2);

  logic        rxs;
  logic        rxs_prev_q;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  samp_q, samp_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;

  logic        maj;
  logic        at_wrap;
  logic        at_last_sample;
  logic        stop_decide;

  rx_synchronizer #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rxs)
  );

  assign at_wrap        = (cnt_q == LAST);
  assign at_last_sample = (cnt_q == MID + 16'd1);
  // The third sample is taken live from rxs, so the vote is ready in the M+1 cycle
  assign maj            = majority3(samp_q[0], samp_q[1], rxs);

  // Next-state: frame FSM, baud counter, sampling, and holding-register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready_i;
    fe_d        = 1'b0;
    ov_d        = 1'b0;
    stop_decide = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = at_wrap ? 16'd0 : cnt_q + 16'd1;
      if (cnt_q == MID - 16'd1) samp_d[0] = rxs;
      if (cnt_q == MID)         samp_d[1] = rxs;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          cnt_d   = 16'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (at_last_sample && maj) begin
          // Line came back high mid start bit: treat as a glitch
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (at_wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (at_last_sample) shift_d = {maj, shift_q[7:1]};
        if (at_wrap) begin
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed
        if (at_last_sample) begin
          stop_decide = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop_decide) begin
      if (!maj) begin
        fe_d = 1'b1;
      end else if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      samp_q     <= 2'b00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign framing_error_o = fe_q;
  assign overrun_o       = ov_q;

endmodule
